traffic_signal_monitor: RTL and testbench
=========================================

// Module: traffic_signal_monitor
// PURPOSE
//  Receive-side conflict monitor for the intersection. Sits between the
//  traffic controller's encoded light outputs (HW, CR) and the lamp drivers.
//  Decodes each road's 2-bit light code into one-hot lamp drives and checks
//  the code stream for conflicts, illegal codes, bad sequences and short
//  timing intervals. On any violation it latches a fault code and forces
//  both roads to flashing red until clear.
// PARAMETERS
//  MIN_YELLOW         3  min consecutive YELLOW samples before YELLOW->RED
//  MIN_ALL_RED        2  min consecutive both-RED samples before any RED->GREEN
//  FLASH_HALF_PERIOD  4  cycles on / cycles off of fault flash
// PORTS
//  clock       in   1  single system clock, rising edge
//  clear       in   1  synchronous active-high reset
//  HW          in   2  highway light code: RED=0, YELLOW=1, GREEN=2, 3 illegal
//  CR          in   2  country-road light code, same encoding
//  hw_lamp     out  3  {green,yellow,red} one-hot highway lamp drive
//  cr_lamp     out  3  {green,yellow,red} one-hot country-road lamp drive
//  fault       out  1  latched fault flag
//  fault_code  out  3  0 none, 1 illegal, 2 conflict, 3 sequence,
//                      4 short yellow, 5 short all-red
// BEHAVIOUR
//  - Clear (sync): hw_lamp=cr_lamp=3'b001 (solid red), fault=0, fault_code=0,
//    counters 0, primed=0, flash phase=on, state=RUN. Clear overrides all.
//  - Stage 1: HW/CR registered into hw_q/cr_q each cycle; previous sample held
//    in hw_p/cr_p. Checks are combinational on hw_q/cr_q vs hw_p/cr_p.
//  - Stage 2: lamps, fault and fault_code registered from the checks.
//    Input-to-lamp latency 2 cycles. An offending sample is never displayed.
//  - Checks, evaluated every RUN cycle:
//    1 illegal: hw_q==3 or cr_q==3.
//    2 conflict: hw_q!=RED and cr_q!=RED.
//    3 sequence, per road: GREEN->RED, RED->YELLOW or YELLOW->GREEN.
//      Only GREEN->YELLOW->RED->GREEN and holding are legal.
//    4 short yellow: YELLOW->RED with that road's yellow_cnt < MIN_YELLOW.
//    5 short all-red: RED->GREEN on a road with all_red_cnt < MIN_ALL_RED.
//  - Simultaneous violations: the lowest code number is latched.
//  - primed=0 for the first sample after clear. That sample gets checks 1 and
//    2 only. primed sets on the next cycle.
//  - Counters:
//    - yellow_cnt (per road) counts consecutive YELLOW samples and saturates
//      at MIN_YELLOW. It resets to 0 on any non-YELLOW sample.
//    - all_red_cnt counts consecutive both-RED samples and saturates at
//      MIN_ALL_RED. It resets otherwise.
//    - Counters are sized $clog2(max+1).
//  - FSM: RUN and FAULT.
//    - RUN->FAULT on any check firing. fault=1 and fault_code are latched on
//      the same edge.
//    - FAULT is sticky. Only clear exits it. Inputs are ignored, and later
//      violations do not overwrite fault_code.
//  - FAULT lamps: yellow/green bits 0. Both red bits toggle together.
//    - The first FAULT cycle is ON; the on phase lasts FLASH_HALF_PERIOD
//      cycles, then the off phase lasts FLASH_HALF_PERIOD cycles, repeating.
//    - The flash counter wraps at FLASH_HALF_PERIOD-1.
//  - RUN lamps: one-hot decode of hw_q/cr_q, i.e. RED->001, YELLOW->010,
//    GREEN->100.
//  - Clear asserted mid-fault or mid-sequence: next edge gives reset values.
//    The post-clear first sample is unprimed, so controller restart at
//    HW=GREEN/CR=RED is accepted.
// TESTING
//  1 clear; HW/CR = 2/0 x5, 1/0 x3, 0/0 x2, 0/2 x4, 0/1 x3, 0/0 x2, 2/0
//    -> fault stays 0; lamps track the inputs 2 cycles late.
//  2 RUN, HW=2 CR=2 for 1 cycle -> fault=1, code=2 two cycles later;
//    red bits 1 for 4 cycles, 0 for 4, repeating; green/yellow never lit.
//  3 HW 2->0 directly with CR=0 -> code=3; the HW red lamp is never shown
//    before flashing.
//  4 HW yellow for 2 cycles, then red -> code=4. Repeat with 3 yellow cycles
//    -> no fault.
//  5 HW=3 together with CR=2 -> code=1 (priority over 2). Then drive further
//    violations -> code stays 1.
//  6 In FAULT, pulse clear 1 cycle; apply HW=2 CR=0 -> lamps 001/001 during
//    clear; fault=0; HW green shown 2 cycles after the sample; no fault.

Source files
------------

// File: rtl/traffic_signal_monitor.sv
// Receive-side conflict monitor: registers the controller's light codes, checks them for
// illegal/conflicting/out-of-order/short-interval patterns and drives lamps, flashing red on fault.
module traffic_signal_monitor #(
  parameter int MIN_YELLOW        = 3,
  parameter int MIN_ALL_RED       = 2,
  parameter int FLASH_HALF_PERIOD = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [1:0] HW,
  input  logic [1:0] CR,
  output logic [2:0] hw_lamp,
  output logic [2:0] cr_lamp,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int AW = $clog2(MIN_ALL_RED + 1);
  localparam int FW = (FLASH_HALF_PERIOD > 1) ? $clog2(FLASH_HALF_PERIOD) : 1;

  localparam logic [1:0] RED     = 2'd0;
  localparam logic [1:0] YELLOW  = 2'd1;
  localparam logic [1:0] GREEN   = 2'd2;
  localparam logic [1:0] ILLEGAL = 2'd3;

  localparam logic [2:0] CODE_NONE      = 3'd0;
  localparam logic [2:0] CODE_ILLEGAL   = 3'd1;
  localparam logic [2:0] CODE_CONFLICT  = 3'd2;
  localparam logic [2:0] CODE_SEQUENCE  = 3'd3;
  localparam logic [2:0] CODE_SHORT_YEL = 3'd4;
  localparam logic [2:0] CODE_SHORT_AR  = 3'd5;

  localparam logic [2:0] LAMP_RED = 3'b001;

  typedef enum logic {RUN, FAULT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      hw_q, cr_q, hw_p, cr_p;
  logic            q_valid, primed;
  logic [YW-1:0]   hw_ycnt, cr_ycnt;
  logic [AW-1:0]   all_red_cnt;
  logic [FW-1:0]   flash_cnt, flash_cnt_d;
  logic            flash_on, flash_on_d;
  logic [2:0]      vio_code;
  logic [2:0]      hw_lamp_d, cr_lamp_d, fault_code_d;
  logic            fault_d;

  function automatic logic [2:0] decode(input logic [1:0] code);
    case (code)
      YELLOW:  return 3'b010;
      GREEN:   return 3'b100;
      default: return LAMP_RED;
    endcase
  endfunction

  // Only GREEN->YELLOW->RED->GREEN steps (or holding) are legal.
  function automatic logic bad_step(input logic [1:0] p, input logic [1:0] q);
    return (p == GREEN && q == RED) || (p == RED && q == YELLOW) || (p == YELLOW && q == GREEN);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (clear) begin
      hw_q    <= RED;
      cr_q    <= RED;
      hw_p    <= RED;
      cr_p    <= RED;
      q_valid <= 1'b0;
      primed  <= 1'b0;
    end else begin
      hw_p    <= hw_q;
      cr_p    <= cr_q;
      hw_q    <= HW;
      cr_q    <= CR;
      q_valid <= 1'b1;
      primed  <= q_valid;
    end
  end

  // Run-length counters describe the samples up to and including hw_p/cr_p when checked.
  always_ff @(posedge clock) begin
    if (clear) begin
      hw_ycnt     <= '0;
      cr_ycnt     <= '0;
      all_red_cnt <= '0;
    end else if (q_valid && state_q == RUN) begin
      hw_ycnt <= (hw_q != YELLOW) ? '0 :
                 (hw_ycnt == YW'(MIN_YELLOW)) ? hw_ycnt : hw_ycnt + YW'(1);
      cr_ycnt <= (cr_q != YELLOW) ? '0 :
                 (cr_ycnt == YW'(MIN_YELLOW)) ? cr_ycnt : cr_ycnt + YW'(1);
      all_red_cnt <= (hw_q != RED || cr_q != RED) ? '0 :
                     (all_red_cnt == AW'(MIN_ALL_RED)) ? all_red_cnt : all_red_cnt + AW'(1);
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    vio_code = CODE_NONE;
    if (q_valid) begin
      if (hw_q == ILLEGAL || cr_q == ILLEGAL) begin
        vio_code = CODE_ILLEGAL;
      end else if (hw_q != RED && cr_q != RED) begin
        vio_code = CODE_CONFLICT;
      end else if (primed) begin
        if (bad_step(hw_p, hw_q) || bad_step(cr_p, cr_q)) begin
          vio_code = CODE_SEQUENCE;
        end else if ((hw_p == YELLOW && hw_q == RED && hw_ycnt < YW'(MIN_YELLOW)) ||
                     (cr_p == YELLOW && cr_q == RED && cr_ycnt < YW'(MIN_YELLOW))) begin
          vio_code = CODE_SHORT_YEL;
        end else if (((hw_p == RED && hw_q == GREEN) || (cr_p == RED && cr_q == GREEN)) &&
                     all_red_cnt < AW'(MIN_ALL_RED)) begin
          vio_code = CODE_SHORT_AR;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    fault_d      = fault;
    fault_code_d = fault_code;
    flash_cnt_d  = flash_cnt;
    flash_on_d   = flash_on;
    hw_lamp_d    = decode(hw_q);
    cr_lamp_d    = decode(cr_q);
    case (state_q)
      RUN: begin
        // The offending sample is replaced by the first ON phase of the flash.
        if (vio_code != CODE_NONE) begin
          state_d      = FAULT;
          fault_d      = 1'b1;
          fault_code_d = vio_code;
          flash_cnt_d  = '0;
          flash_on_d   = 1'b1;
          hw_lamp_d    = LAMP_RED;
          cr_lamp_d    = LAMP_RED;
        end
      end
      FAULT: begin
        if (flash_cnt == FW'(FLASH_HALF_PERIOD - 1)) begin
          flash_cnt_d = '0;
          flash_on_d  = ~flash_on;
        end else begin
          flash_cnt_d = flash_cnt + FW'(1);
        end
        hw_lamp_d = {2'b00, flash_on_d};
        cr_lamp_d = {2'b00, flash_on_d};
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= RUN;
      fault      <= 1'b0;
      fault_code <= CODE_NONE;
      flash_cnt  <= '0;
      flash_on   <= 1'b1;
      hw_lamp    <= LAMP_RED;
      cr_lamp    <= LAMP_RED;
    end else begin
      state_q    <= state_d;
      fault      <= fault_d;
      fault_code <= fault_code_d;
      flash_cnt  <= flash_cnt_d;
      flash_on   <= flash_on_d;
      hw_lamp    <= hw_lamp_d;
      cr_lamp    <= cr_lamp_d;
    end
  end

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Bench for traffic_signal_monitor: a directed vector table, hand-written corner sequences and
// randomized stimulus checked against a sample-history reference model.
module tb_traffic_signal_monitor;

  localparam int MIN_YELLOW = 3;
  localparam int MIN_ALL_RED = 2;
  localparam int FLASH_HALF = 4;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic [1:0] HW = 2'd0;
  logic [1:0] CR = 2'd0;
  logic [2:0] hw_lamp, cr_lamp, fault_code;
  logic       fault;

  int tests = 0;
  int failed = 0;

  traffic_signal_monitor #(
    .MIN_YELLOW(MIN_YELLOW), .MIN_ALL_RED(MIN_ALL_RED), .FLASH_HALF_PERIOD(FLASH_HALF)
  ) dut (
    .clock(clock), .clear(clear), .HW(HW), .CR(CR),
    .hw_lamp(hw_lamp), .cr_lamp(cr_lamp), .fault(fault), .fault_code(fault_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       clr;
    logic [1:0] hw, cr;
    logic [2:0] hl, cl;
    logic       f;
    logic [2:0] code;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic clr, input logic [1:0] hw, input logic [1:0] cr,
                             input logic [2:0] hl, input logic [2:0] cl, input logic f,
                             input logic [2:0] code);
    vec_t r;
    r.clr = clr; r.hw = hw; r.cr = cr; r.hl = hl; r.cl = cl; r.f = f; r.code = code;
    return r;
  endfunction

  // Reference model: keeps every accepted sample since clear and judges each new one by
  // scanning that history; lamps are predicted for the edge after the sample is captured.
  int         hist_hw[$];
  int         hist_cr[$];
  logic [2:0] m_hl, m_cl, m_code;
  logic       m_fault;
  int         m_age;
  bit         pend_valid;
  int         pend_hw, pend_cr;

  function automatic int run_len(input int which);
    int n = 0;
    for (int i = hist_hw.size() - 1; i >= 0; i--) begin
      bit hit;
      case (which)
        0:       hit = (hist_hw[i] == 1);
        1:       hit = (hist_cr[i] == 1);
        default: hit = (hist_hw[i] == 0 && hist_cr[i] == 0);
      endcase
      if (!hit) break;
      n++;
    end
    return n;
  endfunction

  function automatic bit legal_step(input int p, input int q);
    return (q == p) || (q == (p + 2) % 3);
  endfunction

  function automatic logic [2:0] judge(input int h, input int c);
    int n = hist_hw.size();
    int ph, pc;
    if (h == 3 || c == 3) return 3'd1;
    if (h != 0 && c != 0) return 3'd2;
    if (n == 0) return 3'd0;
    ph = hist_hw[n-1];
    pc = hist_cr[n-1];
    if (!legal_step(ph, h) || !legal_step(pc, c)) return 3'd3;
    if ((ph == 1 && h == 0 && run_len(0) < MIN_YELLOW) ||
        (pc == 1 && c == 0 && run_len(1) < MIN_YELLOW)) return 3'd4;
    if (((ph == 0 && h == 2) || (pc == 0 && c == 2)) && run_len(2) < MIN_ALL_RED) return 3'd5;
    return 3'd0;
  endfunction

  task automatic model_edge(input logic c, input logic [1:0] h, input logic [1:0] r);
    logic [2:0] code;
    if (c) begin
      hist_hw.delete(); hist_cr.delete();
      m_hl = 3'b001; m_cl = 3'b001; m_fault = 1'b0; m_code = 3'd0; m_age = 0;
      pend_valid = 1'b0;
      return;
    end
    if (m_fault) begin
      m_age++;
      m_hl = (((m_age / FLASH_HALF) % 2) == 0) ? 3'b001 : 3'b000;
      m_cl = m_hl;
    end else if (pend_valid) begin
      code = judge(pend_hw, pend_cr);
      if (code != 3'd0) begin
        m_fault = 1'b1; m_code = code; m_age = 0;
        m_hl = 3'b001; m_cl = 3'b001;
      end else begin
        m_hl = 3'b001 << pend_hw;
        m_cl = 3'b001 << pend_cr;
        hist_hw.push_back(pend_hw);
        hist_cr.push_back(pend_cr);
      end
    end else begin
      m_hl = 3'b001; m_cl = 3'b001;
    end
    pend_hw = int'(h);
    pend_cr = int'(r);
    pend_valid = 1'b1;
  endtask

  task automatic step(input logic c, input logic [1:0] h, input logic [1:0] r);
    clear = c; HW = h; CR = r;
    @(posedge clock);
    model_edge(c, h, r);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] hl, input logic [2:0] cl,
                       input logic f, input logic [2:0] code);
    tests++;
    if (hw_lamp !== hl || cr_lamp !== cl || fault !== f || fault_code !== code) begin
      failed++;
      $display("FAIL %s: got hw=%b cr=%b fault=%b code=%0d, want hw=%b cr=%b fault=%b code=%0d",
               name, hw_lamp, cr_lamp, fault, fault_code, hl, cl, f, code);
    end
  endtask

  initial begin
    logic [1:0] cur_hw, cur_cr;
    logic       clr;

    // Legal cycle with lamps two edges behind, then a one-cycle conflict and the flash pattern.
    tbl.push_back(v(1, 0, 0, 3'b001, 3'b001, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0, 2, 0, (i == 0) ? 3'b001 : 3'b100, 3'b001, 0, 0));
    tbl.push_back(v(0, 1, 0, 3'b100, 3'b001, 0, 0));
    tbl.push_back(v(0, 1, 0, 3'b010, 3'b001, 0, 0));
    tbl.push_back(v(0, 1, 0, 3'b010, 3'b001, 0, 0));
    tbl.push_back(v(0, 0, 0, 3'b010, 3'b001, 0, 0));
    tbl.push_back(v(0, 0, 0, 3'b001, 3'b001, 0, 0));
    tbl.push_back(v(0, 0, 2, 3'b001, 3'b001, 0, 0));
    tbl.push_back(v(0, 0, 2, 3'b001, 3'b100, 0, 0));
    tbl.push_back(v(0, 0, 2, 3'b001, 3'b100, 0, 0));
    tbl.push_back(v(0, 0, 2, 3'b001, 3'b100, 0, 0));
    tbl.push_back(v(0, 0, 1, 3'b001, 3'b100, 0, 0));
    tbl.push_back(v(0, 0, 1, 3'b001, 3'b010, 0, 0));
    tbl.push_back(v(0, 0, 1, 3'b001, 3'b010, 0, 0));
    tbl.push_back(v(0, 0, 0, 3'b001, 3'b010, 0, 0));
    tbl.push_back(v(0, 0, 0, 3'b001, 3'b001, 0, 0));
    tbl.push_back(v(0, 2, 0, 3'b001, 3'b001, 0, 0));
    tbl.push_back(v(0, 2, 0, 3'b100, 3'b001, 0, 0));
    tbl.push_back(v(0, 2, 2, 3'b100, 3'b001, 0, 0));
    tbl.push_back(v(0, 0, 0, 3'b001, 3'b001, 1, 2));
    tbl.push_back(v(0, 3, 3, 3'b001, 3'b001, 1, 2));
    tbl.push_back(v(0, 2, 2, 3'b001, 3'b001, 1, 2));
    tbl.push_back(v(0, 1, 0, 3'b001, 3'b001, 1, 2));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(0, 2'(i), 2, 3'b000, 3'b000, 1, 2));
    tbl.push_back(v(0, 0, 0, 3'b001, 3'b001, 1, 2));
    tbl.push_back(v(0, 0, 0, 3'b001, 3'b001, 1, 2));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].clr, tbl[i].hw, tbl[i].cr);
      check($sformatf("table[%0d]", i), tbl[i].hl, tbl[i].cl, tbl[i].f, tbl[i].code);
    end

    // Green straight to red: the bad red sample is never shown as a normal lamp.
    step(1, 0, 0); check("seq_clear", 3'b001, 3'b001, 0, 0);
    step(0, 2, 0);
    step(0, 2, 0); check("seq_green", 3'b100, 3'b001, 0, 0);
    step(0, 0, 0); check("seq_pre", 3'b100, 3'b001, 0, 0);
    step(0, 0, 0); check("seq_fault", 3'b001, 3'b001, 1, 3);

    // Two yellows are too short; three are enough.
    step(1, 0, 0); check("shorty_clear", 3'b001, 3'b001, 0, 0);
    step(0, 2, 0); step(0, 2, 0);
    step(0, 1, 0); check("shorty_g", 3'b100, 3'b001, 0, 0);
    step(0, 1, 0); check("shorty_y", 3'b010, 3'b001, 0, 0);
    step(0, 0, 0); check("shorty_y2", 3'b010, 3'b001, 0, 0);
    step(0, 0, 0); check("shorty_fault", 3'b001, 3'b001, 1, 4);
    step(1, 0, 0);
    step(0, 2, 0); step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    step(0, 0, 0); step(0, 0, 0); check("yellow3_ok", 3'b001, 3'b001, 0, 0);
    step(0, 0, 0); check("yellow3_hold", 3'b001, 3'b001, 0, 0);

    // Illegal outranks conflict, and the latched code survives later violations.
    step(1, 0, 0);
    step(0, 2, 0);
    step(0, 3, 2); check("illegal_pre", 3'b100, 3'b001, 0, 0);
    step(0, 2, 2); check("illegal_fault", 3'b001, 3'b001, 1, 1);
    step(0, 0, 3); step(0, 1, 1); check("illegal_sticky", 3'b001, 3'b001, 1, 1);

    // One-cycle clear out of FAULT, then a restart at highway green is accepted.
    step(1, 2, 0); check("restart_clear", 3'b001, 3'b001, 0, 0);
    step(0, 2, 0); check("restart_s0", 3'b001, 3'b001, 0, 0);
    step(0, 2, 0); check("restart_green", 3'b100, 3'b001, 0, 0);
    step(0, 2, 0); check("restart_hold", 3'b100, 3'b001, 0, 0);

    // Random controller-like stimulus: mostly hold or advance, occasional arbitrary codes.
    step(1, 0, 0);
    cur_hw = 2'd0; cur_cr = 2'd0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      clr = m_fault ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 499) == 0);
      r = $urandom_range(0, 99);
      if (r >= 96)      cur_hw = 2'($urandom_range(0, 3));
      else if (r >= 75) cur_hw = (cur_hw == 2'd3) ? 2'd0 : 2'((int'(cur_hw) + 2) % 3);
      r = $urandom_range(0, 99);
      if (r >= 97)      cur_cr = 2'($urandom_range(0, 3));
      else if (r >= 75 && !(cur_cr == 2'd0 && cur_hw != 2'd0 && r < 93))
        cur_cr = (cur_cr == 2'd3) ? 2'd0 : 2'((int'(cur_cr) + 2) % 3);
      step(clr, cur_hw, cur_cr);
      check("random", m_hl, m_cl, m_fault, m_code);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
